dmi_arbiter: RTL

//   Shares the single Debug Module DMI port between two debug hosts: m0 (JTAG DTM, post-CDC) and m1 (second host, e.g. UART bridge).

---
 rtl/dmi_pkg.sv | 27 ++
 rtl/dmi_rr_arb2.sv | 27 ++
 rtl/dmi_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg
//   Shared definitions for the DMI arbiter slice: default field widths,
//   packed request width, DMI op/response encodings and the arbiter FSM
//   state type.
package dmi_pkg;

  localparam int DEF_ADDR_BITS = 6;
  localparam int DEF_DATA_BITS = 32;
  localparam int DEF_OP_BITS   = 2;
  localparam int REQ_BITS      = DEF_ADDR_BITS + DEF_DATA_BITS + DEF_OP_BITS;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_FAILED = 2'b10;
  localparam logic [1:0] RESP_BUSY   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dmi_state_e;

endpackage

// File: rtl/dmi_rr_arb2.sv
// dmi_rr_arb2
//   Combinational two-way round-robin pick.
// Ports
//   req       in  2  request lines, bit i = host i
//   last      in  1  index of the host served most recently
//   gnt_valid out 1  at least one host is requesting
//   gnt_idx   out 1  index of the winning host
module dmi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // When both hosts request, the one not served last wins; a lone
  // requester always wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter
//   Shares the Debug Module DMI port between two debug hosts (m0 = JTAG DTM,
//   m1 = second host). Round-robin grant, one outstanding transaction; the
//   DM response is returned to the host that issued the request.
//   Optional feature macro: DMI_ARB_TIMEOUT_EN enables a DM response watchdog
//   that answers the host with a FAILED op after TIMEOUT_CYCLES wait cycles
//   and swallows the late DM response.
// Ports
//   clk, rst                    core clock, async active-high reset
//   m0_req_valid_i/data_i       host0 request {addr,data,op}
//   m0_req_ready_o              host0 request accepted
//   m0_resp_valid_o/data_o      host0 response
//   m0_resp_ready_i             host0 takes response
//   m1_*                        same set for host1
//   dm_req_valid_o/data_o       request to the DM
//   dm_req_ready_i              DM accepts request
//   dm_resp_valid_i/data_i      DM response
//   dm_resp_ready_o             arbiter takes DM response
//   busy_o                      a transaction is in progress
//   grant_o                     index of current/last granted host
module dmi_arbiter #(
  parameter int  DMI_ADDR_BITS  = dmi_pkg::DEF_ADDR_BITS,
  parameter int  DMI_DATA_BITS  = dmi_pkg::DEF_DATA_BITS,
  parameter int  DMI_OP_BITS    = dmi_pkg::DEF_OP_BITS,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int REQ_BITS       = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid_i,
  input  logic [REQ_BITS-1:0] m0_req_data_i,
  output logic                m0_req_ready_o,
  output logic                m0_resp_valid_o,
  output logic [REQ_BITS-1:0] m0_resp_data_o,
  input  logic                m0_resp_ready_i,
  input  logic                m1_req_valid_i,
  input  logic [REQ_BITS-1:0] m1_req_data_i,
  output logic                m1_req_ready_o,
  output logic                m1_resp_valid_o,
  output logic [REQ_BITS-1:0] m1_resp_data_o,
  input  logic                m1_resp_ready_i,
  output logic                dm_req_valid_o,
  output logic [REQ_BITS-1:0] dm_req_data_o,
  input  logic                dm_req_ready_i,
  input  logic                dm_resp_valid_i,
  input  logic [REQ_BITS-1:0] dm_resp_data_i,
  output logic                dm_resp_ready_o,
  output logic                busy_o,
  output logic                grant_o
);

  import dmi_pkg::*;

  dmi_state_e          state;
  logic                rr_last;
  logic                grant;
  logic [REQ_BITS-1:0] req_q;
  logic [REQ_BITS-1:0] resp_q;
  logic [1:0]          arb_req;
  logic                gnt_valid;
  logic                gnt_idx;
  logic                arb_enable;
  logic                host_accept;
  logic                resp_take;
  logic                idle_block;

  assign arb_req = {m1_req_valid_i, m0_req_valid_i};

  dmi_rr_arb2 u_rr_arb2 (
    .req       (arb_req),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Grants are only offered in IDLE; the timeout build additionally holds
  // them off until a timed-out DM response has been drained.
  assign arb_enable     = (state == ST_IDLE) && !idle_block;
  assign m0_req_ready_o = arb_enable && gnt_valid && !gnt_idx;
  assign m1_req_ready_o = arb_enable && gnt_valid && gnt_idx;
  assign host_accept    = (m0_req_ready_o && m0_req_valid_i) ||
                          (m1_req_ready_o && m1_req_valid_i);

  assign dm_req_valid_o  = (state == ST_REQ);
  assign dm_req_data_o   = req_q;
  assign m0_resp_valid_o = (state == ST_RESP) && !grant;
  assign m1_resp_valid_o = (state == ST_RESP) && grant;
  assign m0_resp_data_o  = m0_resp_valid_o ? resp_q : '0;
  assign m1_resp_data_o  = m1_resp_valid_o ? resp_q : '0;
  assign resp_take       = grant ? m1_resp_ready_i : m0_resp_ready_i;
  assign busy_o          = (state != ST_IDLE);
  assign grant_o         = grant;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic                stale;
  logic [CNT_BITS-1:0] wait_cnt;
  logic                timeout_hit;

  assign timeout_hit     = (state == ST_WAIT) &&
                           (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
  assign dm_resp_ready_o = (state == ST_WAIT) || stale;
  assign idle_block      = stale;

  // Watchdog: counts WAIT cycles without a DM response. On expiry the
  // transaction is closed with a FAILED answer and the stale flag remembers
  // that the DM still owes a response, which is accepted and dropped later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      if (state == ST_WAIT && !dm_resp_valid_i && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit && !dm_resp_valid_i) begin
        stale <= 1'b1;
      end else if (stale && dm_resp_valid_i) begin
        stale <= 1'b0;
      end
    end
  end
`else
  assign dm_resp_ready_o = (state == ST_WAIT);
  assign idle_block      = 1'b0;
`endif

  // Transaction FSM: accept one host request, forward it to the DM, collect
  // the DM response, hand it back to the granted host, then update the
  // round-robin pointer so the other host wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_last <= 1'b1;
      grant   <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_accept) begin
            req_q <= gnt_idx ? m1_req_data_i : m0_req_data_i;
            grant <= gnt_idx;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dm_req_ready_i) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dm_resp_valid_i) begin
            resp_q <= dm_resp_data_i;
            state  <= ST_RESP;
          end
`ifdef DMI_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            resp_q <= {req_q[REQ_BITS-1 -: DMI_ADDR_BITS],
                       {DMI_DATA_BITS{1'b0}},
                       DMI_OP_BITS'(RESP_FAILED)};
            state  <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (resp_take) begin
            rr_last <= grant;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
